// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fetch-side PC request target with fixed-latency instruction read pipeline and response FIFO
module instr_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2,
  parameter int RSP_DEPTH = 2,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_pc,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [31:0]   rsp_pc,
  output logic          rsp_err,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [31:0]   mem_wdata
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);
  localparam logic [3:0] MAX_OUT = 4'(RSP_DEPTH);

  logic [31:0] mem [DEPTH_WORDS];
  logic [LATENCY-1:0] pv, pe;
  logic [31:0] pi [LATENCY];
  logic [31:0] pp [LATENCY];
  logic [31:0] fi [2**PW];
  logic [31:0] fp [2**PW];
  logic [2**PW-1:0] fe;
  logic [PW-1:0] rd, wr;
  logic [2:0] cnt;
  logic [3:0] outst;
  logic [LATENCY:0] pv_sh;
  logic accept, pop, push, err;
  logic [31:0] rd_data;

  assign err = (req_pc[1:0] != 2'b00) || ({2'b00, req_pc[31:2]} >= 32'(DEPTH_WORDS));
  assign rd_data = mem[req_pc[AW+1:2]];
  assign accept = req_valid && req_ready;
  assign push = pv[LATENCY-1];
  assign pop = rsp_valid && rsp_ready;
  assign pv_sh = {pv, accept};
  assign req_ready = (outst < MAX_OUT) && !flush;
  assign rsp_valid = cnt != 3'd0;
  assign rsp_instr = rsp_valid ? fi[rd] : '0;
  assign rsp_pc = rsp_valid ? fp[rd] : '0;
  assign rsp_err = rsp_valid && fe[rd];

  // outstanding = in-flight pipeline entries + buffered responses
  always_comb begin
    outst = 4'(cnt);
    for (int i = 0; i < LATENCY; i++) outst = outst + 4'(pv[i]);
  end

  // preload port; a same-edge request reads the pre-write word
  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;

  // pipeline valid bits, cleared by flush or reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) pv <= '0;
    else pv <= flush ? '0 : pv_sh[LATENCY-1:0];

  // pipeline payload; errored requests carry a NOP
  always_ff @(posedge clk) begin
    pi[0] <= err ? NOP : rd_data;
    pp[0] <= req_pc;
    pe[0] <= err;
    for (int i = 1; i < LATENCY; i++) begin
      pi[i] <= pi[i-1];
      pp[i] <= pp[i-1];
      pe[i] <= pe[i-1];
    end
  end

  // response FIFO pointers and occupancy; outstanding limit prevents overflow
  always_ff @(posedge clk or negedge rst)
    if (!rst || flush) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr == LAST ? '0 : wr + 1'b1;
      if (pop) rd <= rd == LAST ? '0 : rd + 1'b1;
      cnt <= cnt + 3'(push) - 3'(pop);
    end

  // response FIFO storage
  always_ff @(posedge clk)
    if (push) begin
      fi[wr] <= pi[LATENCY-1];
      fp[wr] <= pp[LATENCY-1];
      fe[wr] <= pe[LATENCY-1];
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed stimulus with queue scoreboard and decoupled response monitor
module tb_instr_mem_responder;
  logic clk = 0, rst = 0, flush = 0, req_valid = 0, rsp_ready = 0, mem_we = 0;
  logic [31:0] req_pc = 0, mem_wdata = 0;
  logic [9:0] mem_waddr = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_instr, rsp_pc;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic err;
    int acc;
    bit lat;
  } exp_t;
  exp_t q[$];

  instr_mem_responder dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_pc(rsp_pc), .rsp_err(rsp_err), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compares the head whenever a pop handshake is about to happen
  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got pc %h expected no response", rsp_pc);
      end else if (rsp_ready) begin
        e = q.pop_front();
        chk("rsp_instr", rsp_instr, e.instr);
        chk("rsp_pc", rsp_pc, e.pc);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        if (e.lat) chk("latency", cyc, e.acc + 2);
      end
    end
  end

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    mem_we = 1;
    mem_waddr = a;
    mem_wdata = d;
    @(posedge clk);
    #1 mem_we = 0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] ei, input logic ee, input bit lat);
    int t = 0;
    exp_t e;
    req_valid = 1;
    req_pc = pc;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got req_ready 0 expected 1 for pc %h", pc);
    end
    @(posedge clk);
    #1;
    e.instr = ei; e.pc = pc; e.err = ee; e.acc = cyc; e.lat = lat;
    q.push_back(e);
    req_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("reset_rsp_instr", rsp_instr, 0);
    chk("reset_rsp_pc", rsp_pc, 0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 0);
    @(negedge clk);
    rst = 1;
    #1 chk("reset_req_ready", {31'b0, req_ready}, 1);
    for (int i = 0; i < 4; i++) wr(10'(i), 32'hA0 + 32'(i));
    // in-order streaming reads
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) send(32'(4 * i), 32'hA0 + 32'(i), 0, 1);
    drain();
    // backpressure: only RSP_DEPTH accepted, head held stable
    rsp_ready = 0;
    send(32'h0, 32'hA0, 0, 0);
    send(32'h4, 32'hA1, 0, 0);
    req_valid = 1;
    req_pc = 32'h8;
    repeat (5) begin
      @(negedge clk);
      chk("full_req_ready", {31'b0, req_ready}, 0);
    end
    chk("held_valid", {31'b0, rsp_valid}, 1);
    chk("held_instr", rsp_instr, 32'hA0);
    chk("held_pc", rsp_pc, 32'h0);
    @(posedge clk);
    #1 rsp_ready = 1;
    @(negedge clk);
    chk("pre_pop_req_ready", {31'b0, req_ready}, 0);
    @(negedge clk);
    chk("post_pop_req_ready", {31'b0, req_ready}, 1);
    @(posedge clk);
    #1;
    q.push_back('{instr: 32'hA2, pc: 32'h8, err: 1'b0, acc: cyc, lat: 1'b0});
    req_valid = 0;
    drain();
    // error responses
    send(32'h6, 32'h13, 1, 1);
    send(32'h1000, 32'h13, 1, 1);
    drain();
    // flush discards in-flight requests and blocks accept
    req_valid = 1;
    req_pc = 32'h0;
    @(posedge clk);
    #1 req_pc = 32'h4;
    @(posedge clk);
    #1;
    flush = 1;
    req_pc = 32'h8;
    @(negedge clk);
    chk("flush_req_ready", {31'b0, req_ready}, 0);
    @(posedge clk);
    #1;
    flush = 0;
    req_valid = 0;
    repeat (4) begin
      @(negedge clk);
      chk("flush_rsp_valid", {31'b0, rsp_valid}, 0);
    end
    @(posedge clk);
    #1 send(32'h8, 32'hA2, 0, 1);
    drain();
    // same-edge preload write returns old data
    mem_we = 1;
    mem_waddr = 10'd1;
    mem_wdata = 32'hBB;
    send(32'h4, 32'hA1, 0, 1);
    mem_we = 0;
    send(32'h4, 32'hBB, 0, 1);
    drain();
    // asynchronous reset with a full buffer
    rsp_ready = 0;
    send(32'hC, 32'hA3, 0, 0);
    send(32'h0, 32'hA0, 0, 0);
    repeat (4) @(negedge clk);
    chk("prerst_valid", {31'b0, rsp_valid}, 1);
    chk("prerst_instr", rsp_instr, 32'hA3);
    #2 rst = 0;
    #1;
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("arst_rsp_instr", rsp_instr, 0);
    chk("arst_rsp_pc", rsp_pc, 0);
    chk("arst_rsp_err", {31'b0, rsp_err}, 0);
    q.delete();
    @(negedge clk);
    rst = 1;
    #1 chk("post_rst_req_ready", {31'b0, req_ready}, 1);
    @(posedge clk);
    #1 rsp_ready = 1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
